simmem_bank_scheduler: RTL

//  Shares the single simulated DRAM bank between the write-address and read-address request streams.

---
 rtl/simmem_bank_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/simmem_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_bank_scheduler
//  Purpose  : Arbitrates write/read address requests onto one simulated DRAM
//             bank, tracks the open row and sequences precharge / activate /
//             access timing before reporting the finished request's iid.
//  Revision : 1.0 - initial release
// ============================================================================
module simmem_bank_scheduler #(
  parameter int unsigned AxAddrWidth    = 20,
  parameter int unsigned RowBufLenW     = 10,
  parameter int unsigned WRspBankAddrW  = 3,
  parameter int unsigned RDataBankAddrW = 5,
  parameter int unsigned RowHitCost     = 4,
  parameter int unsigned PrechargeCost  = 2,
  parameter int unsigned ActivationCost = 1,
  parameter int unsigned MaxHitStreak   = 4,
  localparam int unsigned RowIdWidth    = AxAddrWidth - RowBufLenW,
  localparam int unsigned IidWidth      = (WRspBankAddrW > RDataBankAddrW) ?
                                          WRspBankAddrW : RDataBankAddrW
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      waddr_valid_i,
  output logic                      waddr_ready_o,
  input  logic [AxAddrWidth-1:0]    waddr_addr_i,
  input  logic [WRspBankAddrW-1:0]  waddr_iid_i,
  input  logic                      raddr_valid_i,
  output logic                      raddr_ready_o,
  input  logic [AxAddrWidth-1:0]    raddr_addr_i,
  input  logic [RDataBankAddrW-1:0] raddr_iid_i,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  output logic                      done_bank_o,
  output logic [IidWidth-1:0]       done_iid_o,
  output logic                      row_open_o,
  output logic [RowIdWidth-1:0]     open_row_o
);

  localparam int unsigned MaxCost0 = (RowHitCost > PrechargeCost) ? RowHitCost : PrechargeCost;
  localparam int unsigned MaxCost  = (MaxCost0 > ActivationCost) ? MaxCost0 : ActivationCost;
  localparam int unsigned CntWidth    = $clog2(MaxCost + 1);
  localparam int unsigned StreakWidth = $clog2(MaxHitStreak + 1);

  // rsp_bank_type_e encoding; also used for the last-grant side
  localparam logic WRSP_BANK  = 1'b0;
  localparam logic RDATA_BANK = 1'b1;

  localparam logic [CntWidth-1:0]    HitCnt    = CntWidth'(RowHitCost);
  localparam logic [CntWidth-1:0]    PreCnt    = CntWidth'(PrechargeCost);
  localparam logic [CntWidth-1:0]    ActCnt    = CntWidth'(ActivationCost);
  localparam logic [CntWidth-1:0]    CntOne    = CntWidth'(1);
  localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxHitStreak);
  localparam logic [StreakWidth-1:0] StreakOne = StreakWidth'(1);

  if (RowHitCost < 3) begin : g_chk_row_hit_cost
    $error("RowHitCost must be >= 3");
  end
  if (PrechargeCost < 1) begin : g_chk_precharge_cost
    $error("PrechargeCost must be >= 1");
  end
  if (ActivationCost < 1) begin : g_chk_activation_cost
    $error("ActivationCost must be >= 1");
  end
  if (MaxHitStreak < 1) begin : g_chk_max_hit_streak
    $error("MaxHitStreak must be >= 1");
  end
  if (RowBufLenW >= AxAddrWidth) begin : g_chk_row_buf_len
    $error("RowBufLenW must be smaller than AxAddrWidth");
  end

  typedef enum logic [2:0] {IDLE, PRECHARGE, ACTIVATE, ACCESS, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [StreakWidth-1:0]  streak_q, streak_d;
  logic                    last_grant_q, last_grant_d;
  logic                    side_q, side_d;
  logic [IidWidth-1:0]     iid_q, iid_d;
  logic [RowIdWidth-1:0]   row_q, row_d;
  logic                    row_open_q, row_open_d;
  logic [RowIdWidth-1:0]   open_row_q, open_row_d;

  logic [RowIdWidth-1:0]   waddr_row, raddr_row;
  logic                    waddr_hit, raddr_hit;
  logic                    pick_read, grant, grant_hit;

  // Column bits only select data inside the row buffer, not the bank timing
  logic unused_col_bits;
  assign unused_col_bits = ^{waddr_addr_i[RowBufLenW-1:0], raddr_addr_i[RowBufLenW-1:0]};

  assign waddr_row = waddr_addr_i[AxAddrWidth-1:RowBufLenW];
  assign raddr_row = raddr_addr_i[AxAddrWidth-1:RowBufLenW];
  assign waddr_hit = waddr_valid_i && row_open_q && (waddr_row == open_row_q);
  assign raddr_hit = raddr_valid_i && row_open_q && (raddr_row == open_row_q);

  // Arbiter: streak limit first, then row-hit preference, then round-robin
  always_comb begin
    pick_read = raddr_valid_i;
    if (waddr_valid_i && raddr_valid_i) begin
      if (streak_q == StreakMax) begin
        pick_read = (last_grant_q == WRSP_BANK);
      end else if (waddr_hit != raddr_hit) begin
        pick_read = raddr_hit;
      end else begin
        pick_read = (last_grant_q == WRSP_BANK);
      end
    end
  end

  assign waddr_ready_o = (state_q == IDLE) && waddr_valid_i && !pick_read;
  assign raddr_ready_o = (state_q == IDLE) && raddr_valid_i && pick_read;
  assign grant         = waddr_ready_o || raddr_ready_o;
  assign grant_hit     = pick_read ? raddr_hit : waddr_hit;

  // Next-state logic: request latch, phase sequencing and row bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    last_grant_d = last_grant_q;
    side_d       = side_q;
    iid_d        = iid_q;
    row_d        = row_q;
    row_open_d   = row_open_q;
    open_row_d   = open_row_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          side_d       = pick_read ? RDATA_BANK : WRSP_BANK;
          iid_d        = pick_read ? IidWidth'(raddr_iid_i) : IidWidth'(waddr_iid_i);
          row_d        = pick_read ? raddr_row : waddr_row;
          last_grant_d = pick_read;
          if (waddr_valid_i && raddr_valid_i && (pick_read == last_grant_q)) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakOne;
          end else begin
            streak_d = '0;
          end
          if (grant_hit) begin
            state_d = ACCESS;
            cnt_d   = HitCnt;
          end else if (row_open_q) begin
            state_d    = PRECHARGE;
            cnt_d      = PreCnt;
            row_open_d = 1'b0;
          end else begin
            state_d = ACTIVATE;
            cnt_d   = ActCnt;
          end
        end
      end
      PRECHARGE: begin
        if (cnt_q == CntOne) begin
          state_d = ACTIVATE;
          cnt_d   = ActCnt;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      ACTIVATE: begin
        if (cnt_q == CntOne) begin
          state_d    = ACCESS;
          cnt_d      = HitCnt;
          row_open_d = 1'b1;
          open_row_d = row_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      ACCESS: begin
        if (cnt_q == CntOne) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      streak_q     <= '0;
      last_grant_q <= WRSP_BANK;
      side_q       <= WRSP_BANK;
      iid_q        <= '0;
      row_q        <= '0;
      row_open_q   <= 1'b0;
      open_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      last_grant_q <= last_grant_d;
      side_q       <= side_d;
      iid_q        <= iid_d;
      row_q        <= row_d;
      row_open_q   <= row_open_d;
      open_row_q   <= open_row_d;
    end
  end

  assign done_valid_o = (state_q == DONE);
  assign done_bank_o  = done_valid_o & side_q;
  assign done_iid_o   = done_valid_o ? iid_q : '0;
  assign row_open_o   = row_open_q;
  assign open_row_o   = open_row_q;

endmodule
`default_nettype wire
